// File: rtl/sprite_compositor_pkg.sv
// rtl/sprite_compositor_pkg.sv - shared video geometry and colour-key constants
package sprite_compositor_pkg;
  localparam int VIDEO_WIDTH = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int BITS_PER_COLOR = 12;
  localparam int SPRITE_SIZE = 50;
  localparam logic [BITS_PER_COLOR-1:0] TRANSPARENT = 12'h0F0;
endpackage

// File: rtl/sprite_compositor_box.sv
// rtl/sprite_compositor_box.sv - registered point-in-square test for one sprite
module sprite_box_hit
  import sprite_compositor_pkg::*;
#(
  parameter int SIZE = SPRITE_SIZE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic [9:0] sx,
  input  logic [8:0] sy,
  output logic       in_box
);
  // Far edges are one bit wider so a sprite near the screen edge clips instead of wrapping.
  logic [10:0] x_end;
  logic [9:0]  y_end;

  assign x_end = {1'b0, sx} + 11'(SIZE);
  assign y_end = {1'b0, sy} + 10'(SIZE);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_box <= 1'b0;
    end else begin
      in_box <= (x >= sx) && ({1'b0, x} < x_end) && (y >= sy) && ({1'b0, y} < y_end);
    end
  end
endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - layers hammer over fruit over background, flags opaque overlap per frame
module sprite_compositor #(
  parameter int          SPRITE_SIZE = sprite_compositor_pkg::SPRITE_SIZE,
  parameter int          LATENCY     = 2,
  parameter logic [11:0] TRANSPARENT = sprite_compositor_pkg::TRANSPARENT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        active,
  input  logic [9:0]  fruit_x,
  input  logic [8:0]  fruit_y,
  input  logic [9:0]  hammer_x,
  input  logic [8:0]  hammer_y,
  input  logic [11:0] fruit_color,
  input  logic [11:0] hammer_color,
  input  logic [11:0] bg_color,
  output logic [11:0] color_out,
  output logic        active_out,
  output logic        hit,
  output logic [7:0]  hit_count
);
  import sprite_compositor_pkg::*;

  logic               fruit_box, hammer_box;
  logic               fruit_al, hammer_al;
  logic [LATENCY-1:0] act_sh;
  logic [9:0]         x_sh [LATENCY];
  logic [8:0]         y_sh [LATENCY];
  logic               act_al, fruit_op, hammer_op, overlap_now, frame_end;
  logic               overlap_flag;

  sprite_box_hit #(.SIZE(SPRITE_SIZE)) u_fruit_box (
    .clk(clk), .reset(reset), .x(x), .y(y), .sx(fruit_x), .sy(fruit_y), .in_box(fruit_box)
  );

  sprite_box_hit #(.SIZE(SPRITE_SIZE)) u_hammer_box (
    .clk(clk), .reset(reset), .x(x), .y(y), .sx(hammer_x), .sy(hammer_y), .in_box(hammer_box)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      act_sh <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        x_sh[i] <= '0;
        y_sh[i] <= '0;
      end
    end else begin
      act_sh[0] <= active;
      x_sh[0]   <= x;
      y_sh[0]   <= y;
      for (int i = 1; i < LATENCY; i++) begin
        act_sh[i] <= act_sh[i-1];
        x_sh[i]   <= x_sh[i-1];
        y_sh[i]   <= y_sh[i-1];
      end
    end
  end

  // The box register is already the first stage, so the flags need one stage fewer.
  if (LATENCY > 1) begin : g_flag_dly
    logic [LATENCY-2:0] fruit_sh, hammer_sh;
    always_ff @(posedge clk) begin
      if (reset) begin
        fruit_sh  <= '0;
        hammer_sh <= '0;
      end else begin
        fruit_sh[0]  <= fruit_box;
        hammer_sh[0] <= hammer_box;
        for (int i = 1; i < LATENCY - 1; i++) begin
          fruit_sh[i]  <= fruit_sh[i-1];
          hammer_sh[i] <= hammer_sh[i-1];
        end
      end
    end
    assign fruit_al  = fruit_sh[LATENCY-2];
    assign hammer_al = hammer_sh[LATENCY-2];
  end else begin : g_flag_direct
    assign fruit_al  = fruit_box;
    assign hammer_al = hammer_box;
  end

  assign act_al      = act_sh[LATENCY-1];
  assign fruit_op    = fruit_al && (fruit_color != TRANSPARENT);
  assign hammer_op   = hammer_al && (hammer_color != TRANSPARENT);
  assign overlap_now = act_al && fruit_op && hammer_op;
  assign frame_end   = act_al && (x_sh[LATENCY-1] == 10'(VIDEO_WIDTH - 1))
                              && (y_sh[LATENCY-1] == 9'(VIDEO_HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      color_out    <= '0;
      active_out   <= 1'b0;
      hit          <= 1'b0;
      hit_count    <= '0;
      overlap_flag <= 1'b0;
    end else begin
      active_out <= act_al;
      hit        <= 1'b0;
      if (!act_al)        color_out <= '0;
      else if (hammer_op) color_out <= hammer_color;
      else if (fruit_op)  color_out <= fruit_color;
      else                color_out <= bg_color;
      // The last pixel's own overlap still counts toward this frame.
      if (frame_end) begin
        hit          <= overlap_flag || overlap_now;
        overlap_flag <= 1'b0;
        if ((overlap_flag || overlap_now) && (hit_count != 8'hFF))
          hit_count <= hit_count + 8'd1;
      end else if (overlap_now) begin
        overlap_flag <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - directed scoreboard bench for sprite_compositor
module tb_sprite_compositor;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x, fruit_x, hammer_x;
  logic [8:0]  y, fruit_y, hammer_y;
  logic        active;
  logic [11:0] fruit_color, hammer_color, bg_color, color_out;
  logic        active_out, hit;
  logic [7:0]  hit_count;

  always #5 clk = ~clk;

  sprite_compositor #(.SPRITE_SIZE(50), .LATENCY(LAT), .TRANSPARENT(12'h0F0)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .active(active),
    .fruit_x(fruit_x), .fruit_y(fruit_y), .hammer_x(hammer_x), .hammer_y(hammer_y),
    .fruit_color(fruit_color), .hammer_color(hammer_color), .bg_color(bg_color),
    .color_out(color_out), .active_out(active_out), .hit(hit), .hit_count(hit_count)
  );

  typedef struct {logic [11:0] f; logic [11:0] h; logic [11:0] b;} col_t;
  typedef struct {logic [11:0] c; logic a; logic h; logic [7:0] n;} exp_t;

  col_t col_q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  bit   m_flag;
  int   m_count;

  function automatic bit in_box(int px, int py, int sx, int sy);
    return (px >= sx) && (px < sx + 50) && (py >= sy) && (py < sy + 50);
  endfunction

  task automatic chk(string tag, logic [11:0] got, logic [11:0] want);
    checks++;
    assert (got === want) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  task automatic push_zero();
    exp_t z;
    z.c = '0; z.a = 1'b0; z.h = 1'b0; z.n = '0;
    exp_q.push_back(z);
  endtask

  // One pixel per call; entered and left just after a falling edge.
  task automatic step(int px, int py, bit act, logic [11:0] fc, logic [11:0] hc, logic [11:0] bc);
    col_t cv;
    exp_t e, o;
    bit   fo, ho, ov, fe;
    if (exp_q.size() >= LAT + 1) begin
      o = exp_q.pop_front();
      chk("color_out", color_out, o.c);
      chk("active_out", active_out, o.a);
      chk("hit", hit, o.h);
      chk("hit_count", hit_count, o.n);
    end
    x = 10'(px); y = 9'(py); active = act;
    cv.f = fc; cv.h = hc; cv.b = bc;
    col_q.push_back(cv);
    if (col_q.size() > LAT) begin
      cv = col_q.pop_front();
      fruit_color = cv.f; hammer_color = cv.h; bg_color = cv.b;
    end else begin
      fruit_color = '0; hammer_color = '0; bg_color = '0;
    end
    fo = act && in_box(px, py, fruit_x, fruit_y) && (fc != 12'h0F0);
    ho = act && in_box(px, py, hammer_x, hammer_y) && (hc != 12'h0F0);
    e.a = act;
    e.c = !act ? 12'h000 : ho ? hc : fo ? fc : bc;
    ov = act && fo && ho;
    fe = act && (px == 639) && (py == 479);
    e.h = 1'b0;
    if (fe) begin
      e.h = m_flag || ov;
      if (e.h && m_count < 255) m_count++;
      m_flag = 1'b0;
    end else if (ov) begin
      m_flag = 1'b1;
    end
    e.n = 8'(m_count);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(int px, int py, bit act);
    reset = 1'b1; x = 10'(px); y = 9'(py); active = act;
    @(posedge clk);
    @(negedge clk);
    chk("rst color_out", color_out, 12'h000);
    chk("rst active_out", active_out, 12'h000);
    chk("rst hit", hit, 12'h000);
    chk("rst hit_count", hit_count, 12'h000);
    reset = 1'b0;
    col_q.delete();
    exp_q.delete();
    m_flag = 1'b0;
    m_count = 0;
    repeat (LAT + 1) push_zero();
  endtask

  initial begin
    reset = 1'b1; x = '0; y = '0; active = 1'b0;
    fruit_x = 10'd100; fruit_y = 9'd100; hammer_x = 10'd300; hammer_y = 9'd300;
    fruit_color = '0; hammer_color = '0; bg_color = '0;
    do_reset(0, 0, 0);

    // Single-sprite selection and colour keying
    step(120, 110, 1, 12'hF00, 12'h00F, 12'h123);
    step(120, 110, 1, 12'h0F0, 12'h00F, 12'h123);
    step(149, 149, 1, 12'hABC, 12'h00F, 12'h123);
    step(150, 110, 1, 12'hABC, 12'h00F, 12'h123);
    step(320, 320, 1, 12'hF00, 12'h0FF, 12'h123);
    step(120, 110, 0, 12'hF00, 12'h00F, 12'h123);
    step(639, 479, 1, 12'hF00, 12'h00F, 12'h123);

    // Coincident sprites: hammer wins and the frame records a hit
    fruit_x = 10'd200; fruit_y = 9'd200; hammer_x = 10'd200; hammer_y = 9'd200;
    step(210, 210, 1, 12'hF00, 12'h00F, 12'h123);
    step(400, 400, 1, 12'hF00, 12'h00F, 12'h123);
    step(639, 479, 1, 12'hF00, 12'h00F, 12'h123);
    step(0, 0, 0, 12'hF00, 12'h00F, 12'h123);
    step(0, 0, 1, 12'hF00, 12'h00F, 12'h123);

    // Sprites straddling the bottom-right corner clip instead of wrapping
    fruit_x = 10'd620; fruit_y = 9'd470; hammer_x = 10'd620; hammer_y = 9'd470;
    step(5, 5, 1, 12'hF00, 12'h00F, 12'h123);
    step(0, 470, 1, 12'hF00, 12'h00F, 12'h123);
    step(625, 5, 1, 12'hF00, 12'h00F, 12'h123);
    step(639, 479, 1, 12'hF00, 12'h00F, 12'h123);
    step(639, 479, 1, 12'h0F0, 12'h00F, 12'h123);

    // Saturation over 300 overlapping frames
    fruit_x = 10'd200; fruit_y = 9'd200; hammer_x = 10'd200; hammer_y = 9'd200;
    for (int f = 0; f < 300; f++) begin
      step(210 + (f % 30), 220, 1, 12'hF00 + 12'(f), 12'h00F, 12'h123);
      step(639, 479, 1, 12'hF00, 12'h0F0, 12'h456);
    end

    // Mid-frame reset discards an in-flight overlap
    step(210, 210, 1, 12'hF00, 12'h00F, 12'h123);
    do_reset(320, 240, 1);
    step(100, 100, 1, 12'hF00, 12'h00F, 12'h123);
    step(205, 205, 1, 12'hF00, 12'h0F0, 12'h123);
    step(639, 479, 1, 12'hF00, 12'h00F, 12'h123);
    repeat (LAT + 2) step(0, 0, 0, 12'h000, 12'h000, 12'h000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
